prim_bus_arbiter: RTL
=====================

// Module: prim_bus_arbiter
// PURPOSE
//  Two-master, one-slave arbiter for the 16-bit Prim memory bus (addr/dat/bs/we/ack).
//  Master 0 is the Prim CPU; master 1 is a secondary requester (DMA/video fetch).
//  Round-robin, one access per grant, grant held until slave ack; sits between the masters and the memory.
// PARAMETERS
//  TIMEOUT  255  cycles a granted access may wait for i_ack before forced abort (PRIM_ARB_TIMEOUT_EN only)
//  TOW      8    width of timeout counter; TIMEOUT < 2**TOW
// PORTS
//  i_clk      in   1   clock, all logic on rising edge
//  i_reset    in   1   synchronous, active-high reset
//  i_m0_addr  in   16  master 0 address
//  i_m0_dat   in   16  master 0 write data
//  i_m0_bs    in   2   master 0 byte select; |bs != 0 is the request
//  i_m0_we    in   1   master 0 write enable
//  o_m0_dat   out  16  read data to master 0
//  o_m0_ack   out  1   ack to master 0
//  i_m1_addr, i_m1_dat, i_m1_bs, i_m1_we, o_m1_dat, o_m1_ack: same as master 0, for master 1
//  o_addr     out  16  slave address
//  o_dat      out  16  slave write data
//  o_bs       out  2   slave byte select
//  o_we       out  1   slave write enable
//  i_dat      in   16  slave read data
//  i_ack      in   1   slave ack
//  o_timeout  out  1   one-cycle pulse on forced abort
// BEHAVIOUR
//  - States: IDLE, GNT0, GNT1 (registered); r_last records last master served; reset: IDLE, r_last=1.
//  - IDLE: req from one master -> that GNTx next edge; both -> master != r_last; none -> stay.
//  - Arbitration latency 1 cycle: request visible in cycle n, slave sees it in cycle n+1.
//  - GNTx: slave outputs = master x inputs (combinational mux); o_mx_ack = i_ack; other ack 0.
//  - GNTx and i_ack: r_last<=x, next state IDLE (1 turnaround cycle, no back-to-back grants).
//  - GNTx and master x drops request (bs=00) before ack: back to IDLE, r_last unchanged; acks in IDLE ignored.
//  - IDLE or i_reset high: o_addr=0, o_dat=0, o_bs=00, o_we=0 combinationally; both acks 0; o_timeout 0.
//  - o_m0_dat = o_m1_dat = i_dat (broadcast); validity only via ack.
//  - Master must hold addr/dat/bs/we stable from request until its ack.
//  - Reset mid-access: outputs idle immediately; state IDLE next edge; in-flight ack dropped.
// CONFIGURATION
//  - PRIM_ARB_TIMEOUT_EN defined: counter clears on entering GNTx, increments each GNTx cycle without i_ack;
//    at count == TIMEOUT: o_mx_ack=1 for one cycle, o_mx_dat=16'hDEAD, o_timeout=1, o_bs=00 that cycle,
//    r_last<=x, next IDLE. i_ack in same cycle wins (normal completion, no timeout).
//  - Undefined: no counter, grant waits indefinitely for i_ack, o_timeout tied 0.
// STRUCTURE
//  - Shared include bus_defs.v: state encodings ARB_IDLE/ARB_GNT0/ARB_GNT1, BS_NONE/BS_BYTE/BS_WORD,
//    timeout data constant ARB_TIMEOUT_DAT=16'hDEAD.
//  - Single module; no sub-module (mux + 3-state FSM + optional counter).
// TESTING
//  - m0 read 0x0100, bs=11, slave acks 2 cycles after grant with 0x1234 -> o_addr=0x0100 from cycle 1, o_m0_ack with o_m0_dat=0x1234, m1_ack 0.
//  - After reset both request same cycle -> m0 granted first; keep both requesting -> grants alternate m0,m1,m0 with one IDLE cycle between.
//  - m1 write addr 0x2000 dat 0xBEEF bs=01 -> o_we=1, o_dat=0xBEEF, o_bs=01 only during GNT1; o_we=0 in IDLE.
//  - m0 granted, drops bs to 00 before ack, slave acks late -> no ack to either master, FSM IDLE, m1 then served.
//  - i_reset pulsed mid GNT1 -> o_bs=00/o_we=0 in reset cycle, IDLE after, next m0 request granted normally.
//  - PRIM_ARB_TIMEOUT_EN, TIMEOUT=4, slave never acks -> after 4 grant cycles o_m0_ack=1, o_m0_dat=0xDEAD, o_timeout=1 one cycle.

Source files
------------

// File: rtl/prim_bus_arbiter_pkg.sv
// Shared definitions for the Prim bus arbiter: grant state encoding,
// byte-select codes and the data word returned on a forced abort.
package prim_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_GNT0 = 2'd1,
      ARB_GNT1 = 2'd2
   } arb_state_e;

   localparam logic [1:0]  BS_NONE         = 2'b00;
   localparam logic [1:0]  BS_BYTE         = 2'b01;
   localparam logic [1:0]  BS_WORD         = 2'b11;
   localparam logic [15:0] ARB_TIMEOUT_DAT = 16'hDEAD;

   // A master is requesting whenever any byte lane is selected.
   function automatic logic bs_req(input logic [1:0] bs);
      return (bs != BS_NONE);
   endfunction

endpackage

// File: rtl/prim_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the 16-bit Prim memory bus.
// Master 0 is the CPU, master 1 a secondary requester (DMA / video fetch).
// One access per grant; the grant is held until the slave acks, then the
// arbiter spends one turnaround cycle in IDLE before the next grant.
//
// Optional feature: define PRIM_ARB_TIMEOUT_EN to abort a granted access
// that has waited TIMEOUT cycles for the slave ack. The abort acks the
// owning master with ARB_TIMEOUT_DAT and pulses o_timeout. The TIMEOUT and
// TOW parameters only exist in that build.
module prim_bus_arbiter
   import prim_bus_arbiter_pkg::*;
`ifdef PRIM_ARB_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TOW     = 8
)
`endif
(
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [15:0] i_m0_addr,
   input  logic [15:0] i_m0_dat,
   input  logic [1:0]  i_m0_bs,
   input  logic        i_m0_we,
   output logic [15:0] o_m0_dat,
   output logic        o_m0_ack,
   input  logic [15:0] i_m1_addr,
   input  logic [15:0] i_m1_dat,
   input  logic [1:0]  i_m1_bs,
   input  logic        i_m1_we,
   output logic [15:0] o_m1_dat,
   output logic        o_m1_ack,
   output logic [15:0] o_addr,
   output logic [15:0] o_dat,
   output logic [1:0]  o_bs,
   output logic        o_we,
   input  logic [15:0] i_dat,
   input  logic        i_ack,
   output logic        o_timeout
);

   arb_state_e state_r;
   arb_state_e state_next_s;
   logic       last_r;
   logic       last_next_s;
   logic       req0_s;
   logic       req1_s;
   logic       tmo_hit_s;
   logic       tmo_abort_s;

   assign req0_s = bs_req(i_m0_bs);
   assign req1_s = bs_req(i_m1_bs);

   // A real slave ack in the same cycle as the timeout wins over the abort.
   assign tmo_abort_s = tmo_hit_s & ~i_ack;

`ifdef PRIM_ARB_TIMEOUT_EN
   logic [TOW-1:0] tmo_cnt_r;

   // Count grant cycles spent waiting for the ack; IDLE clears the count so
   // every new grant starts from zero.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tmo_cnt_r <= {TOW{1'b0}};
      end else if (state_r == ARB_IDLE) begin
         tmo_cnt_r <= {TOW{1'b0}};
      end else if (!i_ack && !tmo_hit_s) begin
         tmo_cnt_r <= tmo_cnt_r + {{(TOW-1){1'b0}}, 1'b1};
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end

   assign tmo_hit_s = (state_r != ARB_IDLE) && (tmo_cnt_r == TOW'(TIMEOUT));
`else
   assign tmo_hit_s = 1'b0;
`endif

   // Grant state and last-served master; reset leaves master 1 as last
   // served so master 0 wins the first contested arbitration.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_r <= ARB_IDLE;
         last_r  <= 1'b1;
      end else begin
         state_r <= state_next_s;
         last_r  <= last_next_s;
      end
   end

   // Next-state: round-robin pick in IDLE, release on ack, abort or drop.
   always_comb begin
      state_next_s = state_r;
      last_next_s  = last_r;
      case (state_r)
         ARB_IDLE: begin
            if (req0_s && req1_s) begin
               state_next_s = last_r ? ARB_GNT0 : ARB_GNT1;
            end else if (req0_s) begin
               state_next_s = ARB_GNT0;
            end else if (req1_s) begin
               state_next_s = ARB_GNT1;
            end else begin
               state_next_s = ARB_IDLE;
            end
         end
         ARB_GNT0: begin
            if (i_ack || tmo_hit_s) begin
               state_next_s = ARB_IDLE;
               last_next_s  = 1'b0;
            end else if (!req0_s) begin
               state_next_s = ARB_IDLE;
            end else begin
               state_next_s = ARB_GNT0;
            end
         end
         ARB_GNT1: begin
            if (i_ack || tmo_hit_s) begin
               state_next_s = ARB_IDLE;
               last_next_s  = 1'b1;
            end else if (!req1_s) begin
               state_next_s = ARB_IDLE;
            end else begin
               state_next_s = ARB_GNT1;
            end
         end
         default: begin
            state_next_s = ARB_IDLE;
            last_next_s  = last_r;
         end
      endcase
   end

   // Bus mux: the granted master drives the slave and receives the ack;
   // IDLE and reset present a quiet bus. Read data is broadcast.
   always_comb begin
      o_addr    = 16'h0000;
      o_dat     = 16'h0000;
      o_bs      = BS_NONE;
      o_we      = 1'b0;
      o_m0_ack  = 1'b0;
      o_m1_ack  = 1'b0;
      o_m0_dat  = i_dat;
      o_m1_dat  = i_dat;
      o_timeout = 1'b0;
      if (!i_reset) begin
         case (state_r)
            ARB_GNT0: begin
               o_addr = i_m0_addr;
               o_dat  = i_m0_dat;
               o_bs   = i_m0_bs;
               o_we   = i_m0_we;
               if (tmo_abort_s) begin
                  o_bs      = BS_NONE;
                  o_m0_ack  = 1'b1;
                  o_m0_dat  = ARB_TIMEOUT_DAT;
                  o_timeout = 1'b1;
               end else begin
                  o_m0_ack  = i_ack;
               end
            end
            ARB_GNT1: begin
               o_addr = i_m1_addr;
               o_dat  = i_m1_dat;
               o_bs   = i_m1_bs;
               o_we   = i_m1_we;
               if (tmo_abort_s) begin
                  o_bs      = BS_NONE;
                  o_m1_ack  = 1'b1;
                  o_m1_dat  = ARB_TIMEOUT_DAT;
                  o_timeout = 1'b1;
               end else begin
                  o_m1_ack  = i_ack;
               end
            end
            default: begin
               o_bs = BS_NONE;
            end
         endcase
      end else begin
         o_bs = BS_NONE;
      end
   end

endmodule
